// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: FSM state encodings and settle-timer width shared by the sweeper files
package truth_table_sweeper_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_FIN  = 2'd2
  } state_e;
  localparam int SETTLE_W = 4;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: sweep control, stimulus vector, sampled outputs and result bus
//   master: sweeper side (drives vec/busy/done/results, reads start/s_ref/s_dut)
//   slave : harness side (drives start/s_ref/s_dut, reads everything else)
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [N_IN-1:0]      vec;
  logic                 s_ref;
  logic                 s_dut;
  logic                 busy;
  logic                 done;
  logic                 equal;
  logic [2**N_IN-1:0]   mismatch_mask;
  logic [N_IN:0]        mismatch_count;
  logic [N_IN-1:0]      first_fail;
  modport master (
    input  start, s_ref, s_dut,
    output vec, busy, done, equal, mismatch_mask, mismatch_count, first_fail
  );
  modport slave (
    output start, s_ref, s_dut,
    input  vec, busy, done, equal, mismatch_mask, mismatch_count, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: next-value logic for the per-vector settle down-counter (register lives in the parent)
//   load_i  : reload with value_i
//   value_i : reload value
//   cnt_i   : current count
//   cnt_o   : next count (reload, else decrement, saturating at zero)
//   zero_o  : current count is zero, i.e. this edge samples the vector
module settle_timer
  import truth_table_sweeper_pkg::*;
(
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] value_i,
  input  logic [SETTLE_W-1:0] cnt_i,
  output logic [SETTLE_W-1:0] cnt_o,
  output logic                zero_o
);
  assign zero_o = cnt_i == '0;
  assign cnt_o  = load_i ? value_i : zero_o ? cnt_i : cnt_i - SETTLE_W'(1);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector into a block under test and records ref/dut mismatches
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : truth_table_sweeper_if master (start, vec, s_ref, s_dut, busy, done, results)
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  truth_table_sweeper_if.master bus
);
  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);
  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d, ff_q, ff_d;
  logic [2**N_IN-1:0]  mask_q, mask_d;
  logic [N_IN:0]       count_q, count_d;
  logic                equal_q, equal_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                zero, launch, sample, last, mm;
  assign launch = state_q == ST_IDLE && bus.start;
  assign sample = state_q == ST_HOLD && zero;
  assign last   = vec_q == {N_IN{1'b1}};
  assign mm     = bus.s_ref ^ bus.s_dut;
  settle_timer u_timer (
    .load_i  (launch || (sample && !last)),
    .value_i (RELOAD),
    .cnt_i   (settle_q),
    .cnt_o   (settle_d),
    .zero_o  (zero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      ff_q     <= '0;
      mask_q   <= '0;
      count_q  <= '0;
      equal_q  <= 1'b1;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      ff_q     <= ff_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      equal_q  <= equal_d;
      settle_q <= settle_d;
    end
  end
  always_comb begin
    state_d = state_q == ST_IDLE ? (bus.start ? ST_HOLD : ST_IDLE) :
              state_q == ST_HOLD ? (sample && last ? ST_FIN : ST_HOLD) : ST_IDLE;
  end
  // Incrementing past the last vector wraps to 0, so vec already reads 0 during FIN.
  always_comb begin
    vec_d   = launch ? '0 : sample ? vec_q + N_IN'(1) : vec_q;
    mask_d  = launch ? '0 : mask_q;
    if (sample) mask_d[vec_q] = mm;
    count_d = launch ? '0 : sample ? count_q + (N_IN+1)'(mm) : count_q;
    ff_d    = launch ? '0 : sample && mm && count_q == '0 ? vec_q : ff_q;
    equal_d = launch ? 1'b1 : sample ? equal_q & ~mm : equal_q;
  end
  always_comb begin
    bus.busy           = state_q == ST_HOLD;
    bus.done           = state_q == ST_FIN;
    bus.vec            = vec_q;
    bus.equal          = equal_q;
    bus.mismatch_mask  = mask_q;
    bus.mismatch_count = count_q;
    bus.first_fail     = ff_q;
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for the sweeper (N_IN=3/SETTLE=2 and N_IN=2/SETTLE=1)
module tb_truth_table_sweeper;
  typedef struct packed {
    logic [7:0] mask;
    logic [3:0] cnt;
    logic [2:0] ff;
    logic       eq;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   mode_a = 0;
  int   mode_b = 0;
  exp_t sbq[$];
  logic [9:0] sbq_b[$];
  always #5 clk = ~clk;
  truth_table_sweeper_if #(.N_IN(3)) ifa ();
  truth_table_sweeper_if #(.N_IN(2)) ifb ();
  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  function automatic logic f3(logic [2:0] v);
    return (v[2] & v[1]) | (~v[2] & v[0]);
  endfunction
  always_comb begin
    ifa.s_ref = f3(ifa.vec);
    ifa.s_dut = mode_a == 0 ? f3(ifa.vec) : mode_a == 1 ? f3(ifa.vec) ^ (ifa.vec == 3'd5) : ~f3(ifa.vec);
    ifb.s_ref = ^ifb.vec;
    ifb.s_dut = (^ifb.vec) ^ (mode_b == 1 && ifb.vec == 2'd2);
  end
  function automatic exp_t model_a(int mode);
    exp_t e;
    logic r, d;
    e = '0;
    e.eq = 1'b1;
    for (int v = 7; v >= 0; v--) begin
      r = f3(3'(v));
      d = mode == 0 ? r : mode == 1 ? r ^ (v == 5) : ~r;
      if (r != d) begin
        e.mask[v] = 1'b1;
        e.cnt = e.cnt + 4'd1;
        e.ff = 3'(v);
        e.eq = 1'b0;
      end
    end
    return e;
  endfunction
  task automatic test_reset();
    logic [17:0] got_a;
    logic [11:0] got_b;
    rst_n = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (2) @(negedge clk);
    got_a = {ifa.busy, ifa.done, ifa.vec, ifa.mismatch_mask, ifa.mismatch_count, ifa.first_fail, ifa.equal};
    checks++;
    if (got_a !== {2'b00, 3'd0, 8'h00, 4'd0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_a: got %h want %h", got_a, {2'b00, 3'd0, 8'h00, 4'd0, 3'd0, 1'b1});
    end
    got_b = {ifb.busy, ifb.done, ifb.vec, ifb.mismatch_mask, ifb.mismatch_count, ifb.first_fail, ifb.equal};
    checks++;
    if (got_b !== {2'b00, 2'd0, 4'h0, 3'd0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_b: got %h want %h", got_b, {2'b00, 2'd0, 4'h0, 3'd0, 2'd0, 1'b1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_sweep(input string name, input int mode, input bit repulse);
    exp_t e, got;
    int n, extra;
    mode_a = mode;
    sbq.push_back(model_a(mode));
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    n = 1;
    checks++;
    if (ifa.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b want 1", name, ifa.busy);
    end
    while (ifa.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      ifa.start = repulse && n == 5;
    end
    ifa.start = 1'b0;
    checks++;
    if (n != 17) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles want 17", name, n);
    end
    e = sbq.pop_front();
    got = {ifa.mismatch_mask, ifa.mismatch_count, ifa.first_fail, ifa.equal};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s_results: got mask=%h cnt=%0d ff=%0d eq=%b want mask=%h cnt=%0d ff=%0d eq=%b",
               name, got.mask, got.cnt, got.ff, got.eq, e.mask, e.cnt, e.ff, e.eq);
    end
    checks++;
    if (ifa.vec !== 3'd0 || ifa.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_fin_state: got vec=%0d busy=%b want vec=0 busy=0", name, ifa.vec, ifa.busy);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL %s_single_done: got %0d active cycles after done want 0", name, extra);
    end
    got = {ifa.mismatch_mask, ifa.mismatch_count, ifa.first_fail, ifa.equal};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s_hold: got %h want %h", name, got, e);
    end
  endtask
  task automatic test_back_to_back();
    exp_t e, got;
    int n;
    mode_a = 2;
    sbq.push_back(model_a(2));
    sbq.push_back(model_a(2));
    @(negedge clk);
    ifa.start = 1'b1;
    n = 0;
    while (ifa.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 17) begin
      failures++;
      $display("FAIL b2b_first_latency: got %0d want 17", n);
    end
    e = sbq.pop_front();
    got = {ifa.mismatch_mask, ifa.mismatch_count, ifa.first_fail, ifa.equal};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL b2b_first_results: got %h want %h", got, e);
    end
    @(negedge clk);
    n++;
    checks++;
    if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", ifa.busy, ifa.done);
    end
    @(negedge clk);
    n++;
    ifa.start = 1'b0;
    checks++;
    if (ifa.busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_relaunch: got busy=%b want 1", ifa.busy);
    end
    while (ifa.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 35) begin
      failures++;
      $display("FAIL b2b_second_latency: got %0d want 35", n);
    end
    e = sbq.pop_front();
    got = {ifa.mismatch_mask, ifa.mismatch_count, ifa.first_fail, ifa.equal};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL b2b_second_results: got %h want %h", got, e);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    logic [17:0] got;
    int n, dones;
    mode_a = 1;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    n = 1;
    while (n < 9) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    got = {ifa.busy, ifa.done, ifa.vec, ifa.mismatch_mask, ifa.mismatch_count, ifa.first_fail, ifa.equal};
    checks++;
    if (got !== {2'b00, 3'd0, 8'h00, 4'd0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_abort: got %h want %h", got, {2'b00, 3'd0, 8'h00, 4'd0, 3'd0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d active cycles want 0", dones);
    end
  endtask
  task automatic test_small();
    logic [9:0] e, got;
    int n, bad;
    mode_b = 1;
    sbq_b.push_back({4'b0100, 3'd1, 2'd2, 1'b0});
    @(negedge clk);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    n = 1;
    bad = 0;
    while (ifb.done !== 1'b1 && n < 20) begin
      if (n <= 4 && ifb.vec !== 2'(n - 1)) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL small_vec_order: got %0d out-of-order cycles want 0", bad);
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL small_latency: got %0d want 5", n);
    end
    e = sbq_b.pop_front();
    got = {ifb.mismatch_mask, ifb.mismatch_count, ifb.first_fail, ifb.equal};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL small_results: got %h want %h", got, e);
    end
    @(negedge clk);
    checks++;
    if (ifb.done !== 1'b0 || ifb.busy !== 1'b0) begin
      failures++;
      $display("FAIL small_done_pulse: got done=%b busy=%b want 0 0", ifb.done, ifb.busy);
    end
  endtask
  initial begin
    test_reset();
    test_sweep("same", 0, 1'b0);
    test_sweep("vec5", 1, 1'b0);
    test_sweep("inverted", 2, 1'b0);
    test_sweep("repulse", 1, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_sweep("fresh", 0, 1'b0);
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
